// File: rtl/pixel_collector_pkg.sv
// Shared types and default widths for the pixel result collector.
package pixel_collector_pkg;

    localparam int DEF_X_BITS     = 4;
    localparam int DEF_Y_BITS     = 4;
    localparam int DEF_ITER_BITS  = 8;
    localparam int DEF_ADDR_BITS  = DEF_X_BITS + DEF_Y_BITS;
    localparam int DEF_FIFO_DEPTH = 4;

    // Frame lifecycle: IDLE until armed, COLLECT while pixels arrive, DONE once all are written.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // One buffered result at the default widths: linear frame-buffer address plus iteration count.
    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_ITER_BITS-1:0] iter;
    } res_entry_t;

endpackage

// File: rtl/pixel_collector_if.sv
// Result and frame-memory buses of the collector.
//
// Handshake rules, both buses: a transfer happens on a rising clk edge where
// the source's valid (res_valid / mem_wr_en) and the sink's ready (res_ready /
// mem_ack) are both high. A source holding valid keeps its payload stable until
// that edge; ready seen while valid is low has no effect.
//
// modport slave  : the collector (sinks results, sources memory writes).
// modport master : the environment (workers sourcing results, memory acking writes).
interface pixel_collector_if
    import pixel_collector_pkg::*;
#(
    parameter int NUM_X_BITS = DEF_X_BITS,
    parameter int NUM_Y_BITS = DEF_Y_BITS,
    parameter int ITER_BITS  = DEF_ITER_BITS,
    parameter int ADDR_BITS  = NUM_X_BITS + NUM_Y_BITS
);

    logic                  res_valid;
    logic                  res_ready;
    logic [NUM_X_BITS-1:0] res_x;
    logic [NUM_Y_BITS-1:0] res_y;
    logic [ITER_BITS-1:0]  res_iter;

    logic                  mem_wr_en;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [ITER_BITS-1:0]  mem_wdata;
    logic                  mem_ack;

    modport slave (
        input  res_valid, res_x, res_y, res_iter, mem_ack,
        output res_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output res_valid, res_x, res_y, res_iter, mem_ack,
        input  res_ready, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/pixel_collector_result_fifo.sv
// Small synchronous FIFO buffering collected results ahead of the write stage.
module result_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Push is refused when full; pop is refused when empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/pixel_collector.sv
// Collects out-of-order worker results, converts (x,y) to a linear address and
// writes iteration counts to frame memory, flagging completion of the frame.
module pixel_collector
    import pixel_collector_pkg::*;
#(
    parameter int NUM_X_BITS = DEF_X_BITS,
    parameter int NUM_Y_BITS = DEF_Y_BITS,
    parameter int ITER_BITS  = DEF_ITER_BITS,
    parameter int ADDR_BITS  = NUM_X_BITS + NUM_Y_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_X_BITS-1:0] x_max,
    input  logic [NUM_Y_BITS-1:0] y_max,
    pixel_collector_if.slave      bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  coord_err,
    output logic [ADDR_BITS:0]    pixel_count,
    output state_t                dbg_state
);

    localparam logic [ADDR_BITS:0] ONE = (ADDR_BITS+1)'(1);

    // Same layout as res_entry_t, but at this instance's widths.
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [ITER_BITS-1:0] iter;
    } entry_t;

    state_t                state_q, state_d;
    logic [NUM_X_BITS-1:0] x_max_q;
    logic [NUM_Y_BITS-1:0] y_max_q;
    logic                  start_acc, accept, in_range, push, load, pop;
    logic                  fifo_full, fifo_empty, write_done, last_write;
    logic [ADDR_BITS:0]    width_ext, addr_calc, frame_total;
    entry_t                push_entry, head;
    logic                  wr_en_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [ITER_BITS-1:0]  wdata_q;

    assign start_acc     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign bus.res_ready = (state_q == ST_COLLECT) && !fifo_full;
    assign accept        = bus.res_valid && bus.res_ready;
    assign in_range      = (bus.res_x <= x_max_q) && (bus.res_y <= y_max_q);
    assign push          = accept && in_range;

    // Linear address y*(x_max+1)+x, one bit wider than the address so x_max+1 never wraps.
    assign width_ext   = {{NUM_Y_BITS{1'b0}}, 1'b0, x_max_q} + ONE;
    assign addr_calc   = {{(NUM_X_BITS+1){1'b0}}, bus.res_y} * width_ext
                       + {{(NUM_Y_BITS+1){1'b0}}, bus.res_x};
    assign frame_total = width_ext * ({{(NUM_X_BITS+1){1'b0}}, y_max_q} + ONE);

    assign push_entry.addr = addr_calc[ADDR_BITS-1:0];
    assign push_entry.iter = bus.res_iter;

    // The output register refills whenever it is empty or its write is being acked.
    assign load       = !wr_en_q || bus.mem_ack;
    assign pop        = load && !fifo_empty;
    assign write_done = wr_en_q && bus.mem_ack;
    assign last_write = write_done && ((pixel_count + ONE) == frame_total);

    result_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: arm on start, finish on the ack of the last pixel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)      state_d = ST_COLLECT;
            ST_COLLECT: if (last_write) state_d = ST_DONE;
            ST_DONE:    if (start)      state_d = ST_COLLECT;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Frame configuration and per-frame status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_max_q     <= '0;
            y_max_q     <= '0;
            pixel_count <= '0;
            coord_err   <= 1'b0;
        end else if (start_acc) begin
            x_max_q     <= x_max;
            y_max_q     <= y_max;
            pixel_count <= '0;
            coord_err   <= 1'b0;
        end else begin
            if (write_done)            pixel_count <= pixel_count + ONE;
            if (accept && !in_range)   coord_err   <= 1'b1;
        end
    end

    // Write stage: holds one request stable until acked, then takes the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            wr_en_q <= !fifo_empty;
            if (!fifo_empty) begin
                addr_q  <= head.addr;
                wdata_q <= head.iter;
            end
        end
    end

    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q == ST_COLLECT);
    assign frame_done    = (state_q == ST_DONE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector with a scoreboard of expected memory writes.
module tb_pixel_collector;
    import pixel_collector_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x_max;
    logic [3:0] y_max;
    logic       busy;
    logic       frame_done;
    logic       coord_err;
    logic [8:0] pixel_count;
    state_t     dbg_state;

    pixel_collector_if #(.NUM_X_BITS(4), .NUM_Y_BITS(4), .ITER_BITS(8)) bus();

    pixel_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x_max       (x_max),
        .y_max       (y_max),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .coord_err   (coord_err),
        .pixel_count (pixel_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    res_entry_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int xm, input int ym);
        @(posedge clk); #1;
        start = 1'b1;
        x_max = xm[3:0];
        y_max = ym[3:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one result; the expected write is queued at the edge it is accepted.
    task automatic send(input int x, input int y, input int it, input int ex_addr, input bit in_rng);
        res_entry_t e;
        bit         got;
        got = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_x     = x[3:0];
        bus.res_y     = y[3:0];
        bus.res_iter  = it[7:0];
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.res_ready) begin
                if (in_rng) begin
                    e.addr = ex_addr[7:0];
                    e.iter = it[7:0];
                    exp_q.push_back(e);
                end
                got = 1'b1;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no res_ready, expected accept of (%0d,%0d)", x, y);
        end
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_res_ready"},   32'(bus.res_ready), 32'd0);
        check({tag, "_mem_wr_en"},   32'(bus.mem_wr_en), 32'd0);
        check({tag, "_mem_addr"},    32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_wdata"},   32'(bus.mem_wdata), 32'd0);
        check({tag, "_busy"},        32'(busy),          32'd0);
        check({tag, "_frame_done"},  32'(frame_done),    32'd0);
        check({tag, "_coord_err"},   32'(coord_err),     32'd0);
        check({tag, "_pixel_count"}, 32'(pixel_count),   32'd0);
        check({tag, "_state"},       32'(dbg_state),     32'(ST_IDLE));
    endtask

    // ---------------- scoreboard monitor ----------------
    logic       pend = 1'b0;
    logic [7:0] pend_addr;
    logic [7:0] pend_data;

    always @(negedge clk) begin
        res_entry_t e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("hold_wr_en", 32'(bus.mem_wr_en), 32'd1);
                check("hold_addr",  32'(bus.mem_addr),  32'(pend_addr));
                check("hold_data",  32'(bus.mem_wdata), 32'(pend_data));
            end
            if (bus.mem_wr_en && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr),  32'(e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(e.iter));
                end
                pend = 1'b0;
            end else if (bus.mem_wr_en) begin
                pend      = 1'b1;
                pend_addr = bus.mem_addr;
                pend_data = bus.mem_wdata;
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        x_max         = '0;
        y_max         = '0;
        bus.res_valid = 1'b0;
        bus.res_x     = '0;
        bus.res_y     = '0;
        bus.res_iter  = '0;
        bus.mem_ack   = 1'b0;
        cycles(2);
        rst = 1'b0;
        check_idle("reset");

        // 2x2 frame in order, ack always high, plus write latency.
        bus.mem_ack = 1'b1;
        do_start(1, 1);
        check("t1_busy", 32'(busy), 32'd1);
        send(0, 0, 5, 0, 1);
        check("t1_lat_n", 32'(bus.mem_wr_en), 32'd0);
        cycles(1);
        check("t1_lat_n1",  32'(bus.mem_wr_en), 32'd1);
        check("t1_lat_adr", 32'(bus.mem_addr),  32'd0);
        check("t1_lat_dat", 32'(bus.mem_wdata), 32'd5);
        send(1, 0, 6, 1, 1);
        send(0, 1, 7, 2, 1);
        send(1, 1, 8, 3, 1);
        wait_done("t1");
        check("t1_count",    32'(pixel_count),   32'd4);
        check("t1_not_busy", 32'(busy),          32'd0);
        check("t1_done_rdy", 32'(bus.res_ready), 32'd0);
        check("t1_q_empty",  32'(exp_q.size()),  32'd0);

        // 4x1 frame, out of order arrival.
        do_start(3, 0);
        send(3, 0, 9, 3, 1);
        send(0, 0, 1, 0, 1);
        cycles(4);
        check("t2_busy",  32'(busy),        32'd1);
        check("t2_ndone", 32'(frame_done),  32'd0);
        check("t2_count", 32'(pixel_count), 32'd2);
        send(1, 0, 2, 1, 1);
        send(2, 0, 3, 2, 1);
        wait_done("t2");
        check("t2_count_end", 32'(pixel_count), 32'd4);

        // Backpressure: 4x2 frame, ack held low while 6 results are offered.
        do_start(3, 1);
        bus.mem_ack = 1'b0;
        fork
            begin
                send(0, 0, 10, 0, 1);
                send(1, 0, 11, 1, 1);
                send(2, 0, 12, 2, 1);
                send(3, 0, 13, 3, 1);
                send(0, 1, 14, 4, 1);
                send(1, 1, 15, 5, 1);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("t3_ready_low", 32'(bus.res_ready), 32'd0);
                check("t3_accepted",  32'(exp_q.size()),  32'd5);
                check("t3_wr_en",     32'(bus.mem_wr_en), 32'd1);
                check("t3_addr",      32'(bus.mem_addr),  32'd0);
                check("t3_data",      32'(bus.mem_wdata), 32'd10);
                check("t3_count",     32'(pixel_count),   32'd0);
                @(posedge clk); #1;
                bus.mem_ack = 1'b1;
            end
        join
        send(2, 1, 16, 6, 1);
        send(3, 1, 17, 7, 1);
        wait_done("t3");
        check("t3_count_end", 32'(pixel_count),  32'd8);
        check("t3_q_empty",   32'(exp_q.size()), 32'd0);

        // Out-of-range results are swallowed and flagged.
        do_start(2, 0);
        send(3, 0, 4, 0, 0);
        send(0, 1, 4, 0, 0);
        cycles(3);
        check("t4_no_wr", 32'(bus.mem_wr_en), 32'd0);
        check("t4_err",   32'(coord_err),     32'd1);
        check("t4_count", 32'(pixel_count),   32'd0);
        send(0, 0, 1, 0, 1);
        send(1, 0, 2, 1, 1);
        send(2, 0, 3, 2, 1);
        wait_done("t4");
        check("t4_err_sticky", 32'(coord_err),   32'd1);
        check("t4_count_end",  32'(pixel_count), 32'd3);
        do_start(0, 0);
        check("t4_err_clr", 32'(coord_err), 32'd0);
        send(0, 0, 7, 0, 1);
        wait_done("t4b");
        check("t4b_count", 32'(pixel_count), 32'd1);

        // Reset mid-frame with a pending write and two buffered entries.
        do_start(3, 3);
        bus.mem_ack = 1'b0;
        send(0, 0, 20, 0, 1);
        send(1, 0, 21, 1, 1);
        send(2, 0, 22, 2, 1);
        check("t5_pending", 32'(bus.mem_wr_en), 32'd1);
        check("t5_queued",  32'(exp_q.size()),  32'd3);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("t5_rst");
        bus.mem_ack = 1'b1;
        cycles(5);
        check("t5_no_wr", 32'(bus.mem_wr_en), 32'd0);
        do_start(0, 0);
        check("t5_count0", 32'(pixel_count), 32'd0);
        check("t5_busy",   32'(busy),        32'd1);
        send(0, 0, 9, 0, 1);
        wait_done("t5");
        check("t5_count1", 32'(pixel_count), 32'd1);

        // start during COLLECT is ignored; original x_max keeps driving addresses.
        do_start(1, 1);
        do_start(3, 3);
        check("t6_busy",  32'(busy),        32'd1);
        check("t6_count", 32'(pixel_count), 32'd0);
        send(1, 1, 5, 3, 1);
        send(0, 1, 6, 2, 1);
        send(1, 0, 7, 1, 1);
        send(0, 0, 8, 0, 1);
        wait_done("t6");
        check("t6_count_end", 32'(pixel_count), 32'd4);

        cycles(3);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_collector.md
Name: pixel_collector

Overview:
- Return-side counterpart of the Work_Dispatcher coordinate generator.
- The dispatcher's x/y flex counters hand out pixel coordinates to fractal workers. This block accepts the finished results (x, y, iteration count) back from the workers, in any order.
- It buffers results in a small FIFO, converts each coordinate pair to a linear frame-buffer address and issues handshaked writes to frame memory.
- It signals frame completion once every pixel of the configured frame has been written.

Parameters:
- NUM_X_BITS, 4, width of x coordinate
- NUM_Y_BITS, 4, width of y coordinate
- ITER_BITS, 8, width of iteration result
- ADDR_BITS, NUM_X_BITS+NUM_Y_BITS, frame-buffer address width
- FIFO_DEPTH, 4, result buffer entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  arm a new frame; sampled only in IDLE or DONE
- x_max  in  NUM_X_BITS  last valid x (frame width-1); latched on accepted start
- y_max  in  NUM_Y_BITS  last valid y (frame height-1); latched on accepted start
- res_valid  in  1  worker result valid
- res_ready  out  1  collector can accept result
- res_x  in  NUM_X_BITS  result x coordinate
- res_y  in  NUM_Y_BITS  result y coordinate
- res_iter  in  ITER_BITS  iteration count
- mem_wr_en  out  1  write request to frame memory
- mem_addr  out  ADDR_BITS  write address
- mem_wdata  out  ITER_BITS  write data
- mem_ack  in  1  memory accepted current write
- busy  out  1  high in COLLECT
- frame_done  out  1  high in DONE
- coord_err  out  1  sticky: out-of-range result received this frame
- pixel_count  out  ADDR_BITS+1  writes acknowledged this frame

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; FIFO emptied; pending write dropped.
  - All outputs 0: res_ready, mem_wr_en, mem_addr, mem_wdata, busy, frame_done, coord_err, pixel_count.
  - Reset mid-frame aborts immediately, with no further writes.
- FSM IDLE/COLLECT/DONE:
  - IDLE or DONE with start=1 -> COLLECT. Latch x_max/y_max; clear pixel_count and coord_err; frame_done=0.
  - start in COLLECT is ignored.
  - COLLECT -> DONE on the cycle mem_ack completes the write that makes pixel_count == (x_max+1)*(y_max+1).
  - DONE holds until start or rst.
- Result handshake:
  - res_ready = (state==COLLECT) && FIFO not full.
  - Transfer occurs when res_valid && res_ready at the clk edge.
  - Out-of-range results (res_x>x_max or res_y>y_max) are accepted but discarded: not pushed, no write, coord_err set.
- Address:
  - mem_addr = res_y*(x_max+1)+res_x, computed at FIFO push and stored in the entry.
  - Arithmetic in ADDR_BITS+1 bits, truncated to ADDR_BITS (in range by construction).
- Write stage:
  - One output register holds mem_wr_en/mem_addr/mem_wdata.
  - Loads from FIFO head when empty or on the cycle mem_ack=1; then pops the FIFO.
  - mem_wr_en, mem_addr and mem_wdata stay stable until mem_ack.
  - mem_ack while mem_wr_en=0 is ignored.
  - Latency: result accepted at edge N with FIFO and output empty -> mem_wr_en=1 after edge N+1.
  - Back-to-back acks sustain one write per cycle.
- pixel_count increments once per (mem_wr_en && mem_ack).
  - Duplicate coordinates are written and counted again; the bench must not rely on dedup.
- Simultaneous push and pop on a full FIFO is allowed: res_ready is derived from the pre-pop count, so no push occurs when full.
- Results arriving in IDLE/DONE are not accepted (res_ready=0).

Decomposition:
- Package pixel_collector_pkg:
  - state enum typedef
  - result entry struct {addr, iter}
  - default width constants
- Sub-module result_fifo:
  - synchronous FIFO with push, pop, full, empty, data in/out
  - same clk and rst semantics

Test Plan:
- Reset then start with x_max=1, y_max=1; send (0,0,5),(1,0,6),(0,1,7),(1,1,8), mem_ack always 1 -> writes addr 0,1,2,3 with data 5,6,7,8; frame_done=1 after 4th ack; pixel_count=4.
- Out-of-order arrival, x_max=3, y_max=0: send (3,0,9),(0,0,1) -> addr 3 then 0; busy stays 1 until both remaining pixels (1,2) arrive.
- Backpressure: mem_ack=0 for 10 cycles while 6 results are offered, FIFO_DEPTH=4 -> res_ready drops after 4 FIFO pushes plus 1 in the write register; mem_addr/mem_wdata stay stable; no result lost after ack resumes.
- Out-of-range: x_max=2, send (3,0,4) -> no mem_wr_en, coord_err=1, pixel_count unchanged; next start clears coord_err.
- Reset mid-frame: assert rst while mem_wr_en=1 and FIFO holds 2 entries -> next cycle all outputs 0, state IDLE; a new start gives pixel_count=0.
- start during COLLECT with new x_max -> ignored; address computation keeps the original latched x_max.
